// File: rtl/irq_priority_encoder_if.sv
// Request/grant bundle shared by interrupt sources, the priority encoder and its consumer.
// The master side drives requests and acks; the encoder (slave) returns the grant.
interface irq_priority_encoder_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
);
    logic             en;
    logic [N_REQ-1:0] req;
    logic             ack;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic [N_REQ-1:0] pending;

    modport master (output en, req, ack, input idx, valid, pending);
    modport slave  (input en, req, ack, output idx, valid, pending);
endinterface

// File: rtl/irq_priority_encoder.sv
// Edge-latched interrupt priority encoder: pending rising edges are granted highest index
// first, and each grant is held with valid=1 until the consumer acks it.
module irq_priority_encoder #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input logic                   clk,
    input logic                   reset_n,
    irq_priority_encoder_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state, state_next;
    logic [N_REQ-1:0] req_d;
    logic [N_REQ-1:0] pending, pending_next;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] served;
    logic [IDX_W-1:0] idx, idx_next;

    function automatic logic [IDX_W-1:0] highest_set(input logic [N_REQ-1:0] v);
        highest_set = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) highest_set = IDX_W'(i);
        end
    endfunction

    assign rise = bus.req & ~req_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next = state;
        idx_next   = idx;
        served     = '0;
        case (state)
            IDLE: begin
                if (bus.en && (pending != '0)) begin
                    idx_next   = highest_set(pending);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // en is deliberately ignored here: an issued grant is never withdrawn.
                if (bus.ack) begin
                    served[idx] = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A new edge on the bit being acked wins over the clear, so it gets regranted.
        pending_next = (pending & ~served) | (bus.en ? rise : '0);
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            req_d   <= '0;
            pending <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            req_d   <= bus.req;
            pending <= pending_next;
        end
    end

    assign bus.idx     = idx;
    assign bus.valid   = (state == HOLD);
    assign bus.pending = pending;
endmodule

// File: tb/tb_irq_priority_encoder.sv
// Bench for irq_priority_encoder: directed vectors with literal expectations, plus a
// cycle model of the request/grant rules compared against the DUT on every falling edge.
module tb_irq_priority_encoder;
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_miss;

    irq_priority_encoder_if #(.N_REQ(8), .IDX_W(3)) bus ();

    irq_priority_encoder #(.N_REQ(8), .IDX_W(3)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a set of outstanding requests and at most one granted index.
    logic [7:0] m_pending;
    logic [7:0] m_req_d;
    logic       m_valid;
    logic [2:0] m_idx;

    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pending <= 8'h00;
            m_req_d   <= 8'h00;
            m_valid   <= 1'b0;
            m_idx     <= 3'd0;
        end else begin
            if (m_valid) begin
                if (bus.ack) m_valid <= 1'b0;
            end else if (bus.en && m_pending != 8'h00) begin
                m_valid <= 1'b1;
                m_idx   <= 3'(top_bit(m_pending));
            end
            m_pending <= (m_pending & ~((m_valid && bus.ack) ? (8'd1 << m_idx) : 8'd0))
                       | (bus.en ? (bus.req & ~m_req_d) : 8'd0);
            m_req_d   <= bus.req;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("model_valid",   32'(bus.valid),   32'(m_valid));
            check("model_idx",     32'(bus.idx),     32'(m_idx));
            check("model_pending", 32'(bus.pending), 32'(m_pending));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic expect_grant(input string name, input logic [2:0] exp_idx);
        check({name, "_valid"}, 32'(bus.valid), 32'd1);
        check({name, "_idx"},   32'(bus.idx),   32'(exp_idx));
    endtask

    task automatic ack_once();
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        check("ack_drops_valid", 32'(bus.valid), 32'd0);
    endtask

    initial begin
        logic [7:0] decoded;
        n_vec   = 0;
        n_miss  = 0;
        reset_n = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;
        bus.ack = 1'b0;
        repeat (2) cyc();
        check("reset_valid",   32'(bus.valid),   32'd0);
        check("reset_idx",     32'(bus.idx),     32'd0);
        check("reset_pending", 32'(bus.pending), 32'd0);
        reset_n = 1'b1;
        bus.en  = 1'b1;
        cyc();

        // Single pulse on req[2].
        bus.req = 8'h04;
        cyc();
        bus.req = 8'h00;
        check("t1_pending", 32'(bus.pending), 32'h04);
        check("t1_no_valid_yet", 32'(bus.valid), 32'd0);
        cyc();
        expect_grant("t1", 3'd2);
        ack_once();
        check("t1_cleared", 32'(bus.pending), 32'h00);
        cyc();

        // Three simultaneous edges served 7, 4, 1 with one idle cycle between grants.
        bus.req = 8'h92;
        cyc();
        bus.req = 8'h00;
        cyc();
        expect_grant("t2_g7", 3'd7);
        ack_once();
        check("t2_pend_after7", 32'(bus.pending), 32'h12);
        cyc();
        expect_grant("t2_g4", 3'd4);
        ack_once();
        check("t2_pend_after4", 32'(bus.pending), 32'h02);
        cyc();
        expect_grant("t2_g1", 3'd1);
        ack_once();
        check("t2_pend_empty", 32'(bus.pending), 32'h00);
        cyc();

        // Edge while disabled is discarded and never replayed.
        bus.en  = 1'b0;
        bus.req = 8'h20;
        cyc();
        bus.req = 8'h00;
        cyc();
        check("t3_pending", 32'(bus.pending), 32'h00);
        bus.en = 1'b1;
        repeat (2) cyc();
        check("t3_no_grant", 32'(bus.valid), 32'd0);

        // Ack together with a fresh edge on the granted bit: set wins, bit regranted.
        bus.req = 8'h80;
        cyc();
        bus.req = 8'h00;
        cyc();
        expect_grant("t4_first", 3'd7);
        bus.ack = 1'b1;
        bus.req = 8'h80;
        cyc();
        bus.ack = 1'b0;
        check("t4_set_wins", 32'(bus.pending), 32'h80);
        check("t4_gap", 32'(bus.valid), 32'd0);
        cyc();
        expect_grant("t4_regrant", 3'd7);
        bus.req = 8'h00;
        ack_once();
        check("t4_cleared", 32'(bus.pending), 32'h00);

        // Pending held with en=0, stray ack ignored, en=0 does not cancel a grant.
        bus.req = 8'h01;
        cyc();
        bus.en = 1'b0;
        cyc();
        check("idle_en0_pending", 32'(bus.pending), 32'h01);
        check("idle_en0_no_grant", 32'(bus.valid), 32'd0);
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        check("stray_ack_ignored", 32'(bus.pending), 32'h01);
        bus.en = 1'b1;
        cyc();
        expect_grant("idx0", 3'd0);
        bus.en = 1'b0;
        cyc();
        expect_grant("hold_en0", 3'd0);
        ack_once();
        bus.en  = 1'b1;
        bus.req = 8'h00;
        cyc();

        // Higher-priority edge during HOLD does not preempt.
        bus.req = 8'h01;
        cyc();
        cyc();
        expect_grant("nopre_low", 3'd0);
        bus.req = 8'h81;
        cyc();
        expect_grant("nopre_held", 3'd0);
        check("nopre_pending", 32'(bus.pending), 32'h81);
        bus.req = 8'h00;
        ack_once();
        cyc();
        expect_grant("nopre_next", 3'd7);
        ack_once();
        cyc();

        // All eight pending: served strictly from 7 down to 0.
        bus.req = 8'hFF;
        cyc();
        bus.req = 8'h00;
        check("all_pending", 32'(bus.pending), 32'hFF);
        for (int k = 0; k < 8; k++) begin
            cyc();
            expect_grant("all8", 3'(7 - k));
            ack_once();
        end
        check("all8_empty", 32'(bus.pending), 32'h00);
        check("idx_retained", 32'(bus.idx), 32'd0);

        // Asynchronous reset in the middle of a HOLD.
        bus.req = 8'h08;
        cyc();
        cyc();
        expect_grant("t5_pre", 3'd3);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_valid",   32'(bus.valid),   32'd0);
        check("t5_async_idx",     32'(bus.idx),     32'd0);
        check("t5_async_pending", 32'(bus.pending), 32'h00);
        cyc();
        reset_n = 1'b1;
        cyc();
        check("t5_edge_after_release", 32'(bus.pending), 32'h08);
        check("t5_not_yet", 32'(bus.valid), 32'd0);
        cyc();
        expect_grant("t5_regrant", 3'd3);
        bus.req = 8'h00;
        ack_once();
        cyc();

        // Loopback through a 3-to-8 decoder: one-hot regenerated while valid.
        for (int i = 0; i < 8; i++) begin
            bus.req = 8'd1 << i;
            cyc();
            bus.req = 8'h00;
            cyc();
            decoded = bus.valid ? (8'd1 << bus.idx) : 8'h00;
            check("loopback", 32'(decoded), 32'(8'd1 << i));
            ack_once();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
